// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline.
// Tracks the destinations of in-flight instructions (EX, MEM, WB) to pick
// forwarding sources, inserts a one-cycle bubble on load-use and holds issue
// while a branch is outstanding. A taken branch gives a one-cycle flush.
module pipe_hazard_ctrl #(
    parameter int unsigned NREG = 32,
    parameter int unsigned CNTW = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    id_valid,
    input  logic [$clog2(NREG)-1:0] id_rs,
    input  logic [$clog2(NREG)-1:0] id_rt,
    input  logic                    id_use_rs,
    input  logic                    id_use_rt,
    input  logic                    id_wr_en,
    input  logic [$clog2(NREG)-1:0] id_wr_reg,
    input  logic                    id_is_load,
    input  logic                    id_is_branch,
    input  logic                    br_resolve,
    input  logic                    br_taken,
    output logic                    issue,
    output logic                    stall,
    output logic                    flush,
    output logic [1:0]              fwd_rs,
    output logic [1:0]              fwd_rt,
    output logic [CNTW-1:0]         stall_cnt
);

    localparam int unsigned RegW = $clog2(NREG);

    typedef struct packed {
        logic            valid;
        logic            wr_en;
        logic [RegW-1:0] wr_reg;
        logic            is_load;
    } slot_t;

    typedef enum logic [1:0] {StRun, StBrWait, StFlush} state_e;

    slot_t         ex_q, mem_q, wb_q, ex_d;
    state_e        state_q, state_d;
    logic [CNTW-1:0] stall_cnt_q;
    logic          load_use;
    logic          active;

    // A slot only forwards to a source that is actually read and is not r0.
    function automatic logic slot_match(input slot_t s, input logic [RegW-1:0] src,
                                        input logic use_src);
        return s.valid & s.wr_en & (s.wr_reg == src) & (src != '0) & use_src;
    endfunction

    // Youngest producer wins.
    function automatic logic [1:0] fwd_sel(input slot_t ex, input slot_t mem, input slot_t wb,
                                           input logic [RegW-1:0] src, input logic use_src);
        if (slot_match(ex, src, use_src)) return 2'd1;
        if (slot_match(mem, src, use_src)) return 2'd2;
        if (slot_match(wb, src, use_src)) return 2'd3;
        return 2'd0;
    endfunction

    // Outputs are forced quiet while reset is held, since reset is asynchronous.
    assign active = id_valid & ~reset;

    // Hazard detection, issue/stall/flush, forwarding and FSM next state.
    always_comb begin
        state_d  = state_q;
        load_use = ex_q.is_load & (slot_match(ex_q, id_rs, id_use_rs) |
                                   slot_match(ex_q, id_rt, id_use_rt));
        stall    = active & (load_use | (state_q != StRun));
        issue    = active & ~stall;
        flush    = ~reset & (state_q == StFlush);
        fwd_rs   = 2'd0;
        fwd_rt   = 2'd0;
        if (active) begin
            fwd_rs = fwd_sel(ex_q, mem_q, wb_q, id_rs, id_use_rs);
            fwd_rt = fwd_sel(ex_q, mem_q, wb_q, id_rt, id_use_rt);
        end
        unique case (state_q)
            StRun: begin
                // A branch held by load-use only counts once it really issues.
                if (issue && id_is_branch) state_d = StBrWait;
            end
            StBrWait: begin
                if (br_resolve) state_d = br_taken ? StFlush : StRun;
            end
            StFlush: state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // EX slot takes the issuing instruction, or a bubble.
    always_comb begin
        ex_d = '0;
        if (issue) begin
            ex_d.valid   = 1'b1;
            ex_d.wr_en   = id_wr_en;
            ex_d.wr_reg  = id_wr_reg;
            ex_d.is_load = id_is_load;
        end
    end

    // Tracking pipe, FSM state and saturating stall counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            state_q     <= StRun;
            stall_cnt_q <= '0;
        end else begin
            wb_q    <= mem_q;
            mem_q   <= ex_q;
            ex_q    <= ex_d;
            state_q <= state_d;
            if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNTW'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use, r0, branches,
// counter saturation and reset in the middle of a branch wait.
module tb_pipe_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_wr_reg;
    logic       id_use_rs, id_use_rt, id_wr_en, id_is_load, id_is_branch;
    logic       br_resolve, br_taken;
    logic       issue, stall, flush;
    logic [1:0] fwd_rs, fwd_rt;
    logic [3:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipe_hazard_ctrl #(.NREG(32), .CNTW(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_wr_en     (id_wr_en),
        .id_wr_reg    (id_wr_reg),
        .id_is_load   (id_is_load),
        .id_is_branch (id_is_branch),
        .br_resolve   (br_resolve),
        .br_taken     (br_taken),
        .issue        (issue),
        .stall        (stall),
        .flush        (flush),
        .fwd_rs       (fwd_rs),
        .fwd_rt       (fwd_rt),
        .stall_cnt    (stall_cnt)
    );

    always #5 clock = ~clock;

    // Single comparison point: counts and reports.
    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_ctl(input string tag, input int e_issue, input int e_stall,
                              input int e_flush);
        check_val({tag, ".issue"}, 32'(issue), e_issue);
        check_val({tag, ".stall"}, 32'(stall), e_stall);
        check_val({tag, ".flush"}, 32'(flush), e_flush);
    endtask

    task automatic expect_fwd(input string tag, input int e_rs, input int e_rt);
        check_val({tag, ".fwd_rs"}, 32'(fwd_rs), e_rs);
        check_val({tag, ".fwd_rt"}, 32'(fwd_rt), e_rt);
    endtask

    task automatic expect_cnt(input string tag, input int e_cnt);
        check_val({tag, ".stall_cnt"}, 32'(stall_cnt), e_cnt);
    endtask

    // Drive the ID instruction, then let combinational outputs settle.
    task automatic set_id(input int v, input int rs, input int urs, input int rt, input int urt,
                          input int we, input int wr, input int ld, input int br);
        id_valid     = 1'(v);
        id_rs        = 5'(rs);
        id_use_rs    = 1'(urs);
        id_rt        = 5'(rt);
        id_use_rt    = 1'(urt);
        id_wr_en     = 1'(we);
        id_wr_reg    = 5'(wr);
        id_is_load   = 1'(ld);
        id_is_branch = 1'(br);
        #2;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        br_resolve = 1'b0;
        br_taken   = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        br_resolve = 1'b0;
        br_taken   = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Outputs stay quiet under reset even with a valid instruction present.
        set_id(1, 3, 1, 3, 1, 1, 3, 1, 1);
        expect_ctl("rst", 0, 0, 0);
        expect_fwd("rst", 0, 0);
        tick();
        expect_cnt("rst", 0);
        reset = 1'b0;

        // ALU back-to-back and youngest-first forwarding.
        set_id(1, 1, 1, 2, 1, 1, 3, 0, 0);
        expect_ctl("alu0", 1, 0, 0);
        expect_fwd("alu0", 0, 0);
        tick();
        set_id(1, 3, 1, 4, 1, 1, 6, 0, 0);
        expect_ctl("alu1", 1, 0, 0);
        expect_fwd("alu1", 1, 0);
        tick();
        set_id(1, 3, 1, 3, 1, 1, 6, 0, 0);
        expect_ctl("alu2", 1, 0, 0);
        expect_fwd("alu2", 2, 2);
        tick();
        set_id(1, 3, 1, 6, 1, 0, 0, 0, 0);
        expect_fwd("alu3", 3, 1);
        tick();
        set_id(1, 6, 1, 6, 0, 0, 0, 0, 0);
        expect_fwd("alu4", 2, 0);
        tick();
        set_id(0, 6, 1, 6, 1, 0, 0, 0, 0);
        expect_ctl("idle", 0, 0, 0);
        expect_fwd("idle", 0, 0);
        expect_cnt("alu", 0);
        tick();

        // Load-use: one bubble, then MEM forwarding.
        do_reset();
        set_id(1, 1, 1, 2, 0, 1, 5, 1, 0);
        expect_ctl("lw", 1, 0, 0);
        tick();
        set_id(1, 0, 0, 5, 1, 1, 7, 0, 0);
        expect_ctl("lu_stall", 0, 1, 0);
        tick();
        set_id(1, 0, 0, 5, 1, 1, 7, 0, 0);
        expect_ctl("lu_go", 1, 0, 0);
        expect_fwd("lu_go", 0, 2);
        expect_cnt("lu_go", 1);
        tick();
        expect_cnt("lu_after", 1);
        // br_resolve in RUN is ignored.
        br_resolve = 1'b1;
        br_taken   = 1'b1;
        set_id(1, 1, 0, 2, 0, 0, 0, 0, 0);
        expect_ctl("run_res", 1, 0, 0);
        tick();
        br_resolve = 1'b0;
        br_taken   = 1'b0;
        set_id(1, 1, 0, 2, 0, 0, 0, 0, 0);
        expect_ctl("run_ign", 1, 0, 0);
        tick();

        // Branch held by load-use, then not-taken resolution.
        do_reset();
        set_id(1, 1, 1, 2, 0, 1, 5, 1, 0);
        tick();
        set_id(1, 5, 1, 0, 0, 0, 0, 0, 1);
        expect_ctl("br_lu", 0, 1, 0);
        tick();
        set_id(1, 5, 1, 0, 0, 0, 0, 0, 1);
        expect_ctl("br_iss", 1, 0, 0);
        expect_fwd("br_iss", 2, 0);
        tick();
        set_id(1, 1, 0, 2, 0, 1, 9, 0, 0);
        expect_ctl("bw1", 0, 1, 0);
        tick();
        expect_ctl("bw2", 0, 1, 0);
        tick();
        br_resolve = 1'b1;
        br_taken   = 1'b0;
        set_id(1, 1, 0, 2, 0, 1, 9, 0, 0);
        expect_ctl("nt_res", 0, 1, 0);
        tick();
        br_resolve = 1'b0;
        set_id(1, 1, 0, 2, 0, 1, 9, 0, 0);
        expect_ctl("nt_run", 1, 0, 0);
        expect_cnt("nt_run", 4);
        tick();

        // r0 never forwards and never stalls, even from a load.
        do_reset();
        set_id(1, 1, 0, 2, 0, 1, 0, 1, 0);
        tick();
        set_id(1, 0, 1, 0, 1, 0, 0, 0, 0);
        expect_ctl("r0", 1, 0, 0);
        expect_fwd("r0", 0, 0);
        tick();

        // Taken branch: three BR_WAIT cycles, one flush cycle, back to RUN.
        do_reset();
        set_id(1, 1, 1, 2, 1, 0, 0, 0, 1);
        expect_ctl("beq", 1, 0, 0);
        tick();
        set_id(1, 3, 0, 4, 0, 1, 8, 0, 0);
        expect_ctl("tk1", 0, 1, 0);
        tick();
        expect_ctl("tk2", 0, 1, 0);
        tick();
        br_resolve = 1'b1;
        br_taken   = 1'b1;
        set_id(1, 3, 0, 4, 0, 1, 8, 0, 0);
        expect_ctl("tk3", 0, 1, 0);
        tick();
        expect_ctl("tk_fl", 0, 1, 1);
        tick();
        expect_ctl("tk_run", 1, 0, 0);
        expect_cnt("tk_run", 4);
        br_resolve = 1'b0;
        br_taken   = 1'b0;
        tick();
        set_id(1, 3, 0, 4, 0, 1, 8, 0, 0);
        expect_ctl("tk_after", 1, 0, 0);
        tick();

        // Counter saturation, then reset in BR_WAIT abandons the branch.
        do_reset();
        set_id(1, 1, 0, 2, 0, 0, 0, 0, 1);
        tick();
        set_id(1, 3, 1, 4, 0, 1, 8, 0, 0);
        repeat (20) tick();
        expect_ctl("sat", 0, 1, 0);
        expect_cnt("sat", 15);
        reset = 1'b1;
        #2;
        expect_ctl("mid_rst", 0, 0, 0);
        expect_fwd("mid_rst", 0, 0);
        expect_cnt("mid_rst", 0);
        reset      = 1'b0;
        br_resolve = 1'b1;
        br_taken   = 1'b1;
        set_id(1, 3, 1, 4, 0, 1, 8, 0, 0);
        expect_ctl("post_rst", 1, 0, 0);
        tick();
        br_resolve = 1'b0;
        br_taken   = 1'b0;
        set_id(1, 3, 0, 4, 0, 0, 0, 0, 0);
        expect_ctl("post_rst1", 1, 0, 0);
        tick();
        expect_ctl("post_rst2", 1, 0, 0);
        expect_cnt("post_rst2", 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter NREG, default 32, the number of architectural registers (index width 5).
REQ-002 SHALL have parameter CNTW, default 16, the width of the stall counter.
REQ-003 SHALL have port clock, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port id_valid, input, 1, a decoded instruction is present in ID.
REQ-006 SHALL have ports id_rs and id_rt, input, 5 each, the ID source register indices.
REQ-007 SHALL have ports id_use_rs and id_use_rt, input, 1 each, the ID instruction reads rs / rt.
REQ-008 SHALL have ports id_wr_en (input, 1) and id_wr_reg (input, 5), the ID destination write and its index.
REQ-009 SHALL have ports id_is_load and id_is_branch, input, 1 each, the ID instruction is lw / beq-bne.
REQ-010 SHALL have ports br_resolve and br_taken, input, 1 each, WB-stage branch outcome strobe and direction.
REQ-011 SHALL have port issue, output, 1, the ID instruction advances to EX this cycle.
REQ-012 SHALL have port stall, output, 1, hold PC and the ID register.
REQ-013 SHALL have port flush, output, 1, squash the IF/ID contents.
REQ-014 SHALL have ports fwd_rs and fwd_rt, output, 2 each: 0 = register file, 1 = EX result, 2 = MEM result, 3 = WB result.
REQ-015 SHALL have port stall_cnt, output, CNTW, the saturating count of stalled cycles.

Function
REQ-016 SHALL keep a 3-slot tracking pipe (EX, MEM, WB); each slot holds {valid, wr_en, wr_reg, is_load}.
REQ-017 SHALL, on every rising edge, shift WB<=MEM and MEM<=EX; EX SHALL load the ID fields when issue=1 and otherwise load a bubble (valid=0).
REQ-018 SHALL treat a slot as matching source s only when valid=1, wr_en=1, wr_reg==s, s!=0, and the corresponding id_use_* is 1.
REQ-019 SHALL select fwd_* by youngest match first: EX match gives 1, else MEM match gives 2, else WB match gives 3, else 0.
REQ-020 SHALL compute fwd_* combinationally, and SHALL hold fwd_* at 0 whenever id_valid=0.
REQ-021 SHALL raise load-use hazard when the EX slot matches rs or rt and EX.is_load=1.
REQ-022 SHALL implement an FSM with states RUN, BR_WAIT and FLUSH.
REQ-023 SHALL, in RUN, move to BR_WAIT on a cycle with issue=1 and id_is_branch=1, and otherwise remain in RUN.
REQ-024 SHALL, in BR_WAIT, move to FLUSH on br_resolve=1 with br_taken=1, move to RUN on br_resolve=1 with br_taken=0, and otherwise remain in BR_WAIT.
REQ-025 SHALL stay in FLUSH for exactly one cycle and then move to RUN.
REQ-026 SHALL ignore br_resolve while in RUN or FLUSH.
REQ-027 SHALL drive stall = id_valid & (load-use | state!=RUN), combinationally.
REQ-028 SHALL drive issue = id_valid & ~stall; issue and stall SHALL never both be 1.
REQ-029 SHALL drive flush = (state==FLUSH); a FLUSH-state cycle SHALL never issue.
REQ-030 SHALL increment stall_cnt by 1 on each edge where stall=1, saturating at 2^CNTW-1 with no wrap.
REQ-031 SHALL ensure a load-use stall lasts exactly one cycle: after the bubble the load sits in MEM and fwd_* becomes 2.
REQ-032 SHALL ensure that a branch arriving while a load-use hazard is pending does not enter BR_WAIT until it actually issues.

Reset
REQ-033 SHALL, on reset assertion, immediately set all slot valid bits to 0, state to RUN, and stall_cnt to 0.
REQ-034 SHALL, during reset, drive issue=0, stall=0, flush=0 and fwd_rs=fwd_rt=0.
REQ-035 SHALL, on reset mid-BR_WAIT or mid-FLUSH, abandon the pending branch so no flush follows deassertion.
REQ-036 SHALL accept a valid ID instruction on the first edge after reset deassertion.

Verification
REQ-037 SHALL cover ALU back-to-back: add r3 issued, next id_rs=3 use_rs=1 -> fwd_rs=1, stall=0; the cycle after, a reader of r3 sees fwd_rs=2.
REQ-038 SHALL cover load-use: lw r5 issued, next id_rt=5 use_rt=1 -> stall=1 for 1 cycle, then issue=1 with fwd_rt=2, and stall_cnt=1.
REQ-039 SHALL cover the r0 rule: an instruction writing r0, followed by a reader of r0 -> fwd_*=0 and no stall.
REQ-040 SHALL cover taken branch: beq issued, br_resolve=1 br_taken=1 three cycles later -> stall=1 during BR_WAIT, flush=1 for exactly 1 cycle, RUN afterwards.
REQ-041 SHALL cover not-taken branch: br_resolve=1 br_taken=0 -> flush never asserts, and issue resumes the next cycle.
REQ-042 SHALL cover counter saturation and reset: with CNTW=4 and 20 stalled cycles, stall_cnt holds 15; reset pulsed in BR_WAIT -> state RUN, stall_cnt 0, no flush.
